// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with colour/sync alignment stage
// Define VGA_TEST_PATTERN_EN to replace rgb_in with eight vertical colour bars.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int PIX_DIV  = 1,
  parameter int PIX_LAT  = 1,
  parameter int COLOR_W  = 4,
  parameter int HCW      = 11,
  parameter int VCW      = 10
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   RESET_N,
  output logic                   pix_req,
  output logic [HCW-1:0]         pixel_x,
  output logic [VCW-1:0]         pixel_y,
  output logic                   line_start,
  output logic                   frame_start,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_BEG = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]     DIV_LAST = 3'(PIX_DIV - 1);
  localparam logic           HS_ON = 1'(HS_POL);
  localparam logic           VS_ON = 1'(VS_POL);

  if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_widths
    $error("vga_timing_gen: active, porch and sync widths must all be >= 1");
  end
  if (H_TOTAL > (1 << HCW) || V_TOTAL > (1 << VCW)) begin : g_bad_totals
    $error("vga_timing_gen: line/frame totals do not fit HCW/VCW");
  end
  if (PIX_DIV < 1 || PIX_DIV > 8 || PIX_LAT < 0 || PIX_LAT > 4) begin : g_bad_clocking
    $error("vga_timing_gen: PIX_DIV must be 1..8 and PIX_LAT 0..4");
  end

  logic [2:0]     div_q;
  logic [HCW-1:0] h_q;
  logic [VCW-1:0] v_q;
  logic           tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= tick ? 3'd0 : div_q + 3'd1;
      if (tick) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          v_q <= (v_q == V_LAST) ? '0 : v_q + VCW'(1);
        end else begin
          h_q <= h_q + HCW'(1);
        end
      end
    end
  end

  logic act_raw, hs_raw, vs_raw;

  assign act_raw = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw  = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_raw  = (v_q >= VS_BEG) && (v_q < VS_END);

  // Counters sit at zero during reset, so the strobes are gated to stay quiet there.
  assign pix_req     = RESET_N && tick && act_raw;
  assign line_start  = RESET_N && tick && (h_q == '0);
  assign frame_start = line_start && (v_q == '0);
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int PW = 6;
`else
  localparam int PW = 3;
`endif

  logic [PW-1:0] pipe_in;
  logic [PW-1:0] tap;

`ifdef VGA_TEST_PATTERN_EN
  logic [HCW+2:0] hx8;
  logic [2:0]     bar_raw;

  assign hx8     = {h_q, 3'b000};
  assign bar_raw = 3'(hx8 / (HCW+3)'(H_ACTIVE));
  assign pipe_in = {bar_raw, act_raw, hs_raw, vs_raw};
`else
  assign pipe_in = {act_raw, hs_raw, vs_raw};
`endif

  // The output register is the last stage; tap feeds it PIX_LAT clocks after the counters.
  if (PIX_LAT == 0) begin : g_no_delay
    assign tap = pipe_in;
  end else begin : g_delay
    logic [PW-1:0] dl [PIX_LAT];

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        for (int i = 0; i < PIX_LAT; i++) dl[i] <= '0;
      end else begin
        dl[0] <= pipe_in;
        for (int i = 1; i < PIX_LAT; i++) dl[i] <= dl[i-1];
      end
    end

    assign tap = dl[PIX_LAT-1];
  end

  logic [3*COLOR_W-1:0] colour;

`ifdef VGA_TEST_PATTERN_EN
  assign colour = {{COLOR_W{tap[5]}}, {COLOR_W{tap[4]}}, {COLOR_W{tap[3]}}};
`else
  assign colour = rgb_in;
`endif

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= ~HS_ON;
      VGA_VS <= ~VS_ON;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= tap[2] ? colour : '0;
      VGA_HS <= tap[1] ? HS_ON : ~HS_ON;
      VGA_VS <= tap[0] ? VS_ON : ~VS_ON;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HSW = 4, HB = 2;
  localparam int VA = 6,  VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int DIV = 2, LAT = 2, CW = 4;
  localparam int FRAME = DIV * HT * VT;
  localparam logic HP = 1'b0, VP = 1'b1;
  localparam logic HS_IDLE = ~HP, VS_IDLE = ~VP;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pix_req, line_start, frame_start;
  logic [10:0]     pixel_x;
  logic [9:0]      pixel_y;
  logic [3*CW-1:0] rgb_in;
  logic [CW-1:0]   vga_r, vga_g, vga_b;
  logic            vga_hs, vga_vs;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(0), .VS_POL(1), .PIX_DIV(DIV), .PIX_LAT(LAT),
    .COLOR_W(CW), .HCW(11), .VCW(10)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET_N(rst_n),
    .pix_req(pix_req),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .line_start(line_start),
    .frame_start(frame_start),
    .rgb_in(rgb_in),
    .VGA_R(vga_r),
    .VGA_G(vga_g),
    .VGA_B(vga_b),
    .VGA_HS(vga_hs),
    .VGA_VS(vga_vs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3*CW-1:0] rgb;
    logic            hs;
    logic            vs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   t = 0;

  function automatic int h_of(input int c);
    return (c / DIV) % HT;
  endfunction

  function automatic int v_of(input int c);
    return (c / (DIV * HT)) % VT;
  endfunction

  function automatic logic active_of(input int c);
    return (h_of(c) < HA) && (v_of(c) < VA);
  endfunction

  function automatic logic [3*CW-1:0] colour_of(input int c);
`ifdef VGA_TEST_PATTERN_EN
    int k;
    k = (h_of(c) * 8) / HA;
    return {{CW{k[2]}}, {CW{k[1]}}, {CW{k[0]}}};
`else
    return 12'(h_of(c) * 37 + v_of(c) * 291 + 5);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Pushes the expectation for the current counter state and retires the one now visible on the pins.
  task automatic cycle_check();
    logic tk;
    exp_t e, got;
    tk = (t % DIV) == DIV - 1;
    chk("pixel_x", pixel_x, h_of(t));
    chk("pixel_y", pixel_y, v_of(t));
    chk("pix_req", pix_req, tk && active_of(t));
    chk("line_start", line_start, tk && h_of(t) == 0);
    chk("frame_start", frame_start, tk && h_of(t) == 0 && v_of(t) == 0);
    e.rgb = active_of(t) ? colour_of(t) : '0;
    e.hs  = (h_of(t) >= HA + HF && h_of(t) < HA + HF + HSW) ? HP : HS_IDLE;
    e.vs  = (v_of(t) >= VA + VF && v_of(t) < VA + VF + VSW) ? VP : VS_IDLE;
    sb.push_back(e);
    rgb_in = (t >= LAT) ? colour_of(t - LAT) : 12'hA5A;
    if (sb.size() > LAT + 1) begin
      got = sb.pop_front();
      chk("vga_rgb", {vga_r, vga_g, vga_b}, got.rgb);
      chk("vga_hs", vga_hs, got.hs);
      chk("vga_vs", vga_vs, got.vs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    cycle_check();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic release_reset();
    exp_t idle;
    idle.rgb = '0;
    idle.hs  = HS_IDLE;
    idle.vs  = VS_IDLE;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    sb.delete();
    repeat (LAT + 1) sb.push_back(idle);
    #1;
    cycle_check();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_hs"}, vga_hs, HS_IDLE);
    chk({tag, "_vs"}, vga_vs, VS_IDLE);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_pix_req"}, pix_req, 0);
    chk({tag, "_line_start"}, line_start, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_pixel_x"}, pixel_x, 0);
    chk({tag, "_pixel_y"}, pixel_y, 0);
  endtask

  // Runs until the pins show the given raster position, then drops reset between clock edges.
  task automatic mid_reset(input int th, input int tv);
    int guard;
    guard = 0;
    while (!(t >= LAT + 1 && h_of(t - LAT - 1) == th && v_of(t - LAT - 1) == tv) &&
           guard < 2 * FRAME) begin
      step();
      guard++;
    end
    chk("mid_reset_reached", guard < 2 * FRAME, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_hold");
    release_reset();
  endtask

  initial begin
    rgb_in = 12'hFFF;
    repeat (3) @(posedge clk);
    #1;
    check_idle("por");
    release_reset();
    run(2 * FRAME + 40);
    mid_reset(5, 3);
    run(200);
    mid_reset(HA + HF + 1, VA + VF);
    run(FRAME + 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
